// File: rtl/xbit_r_exec.sv
// Execution responder for CB-prefixed rotate/shift/BIT/RES/SET on 8-bit registers.
// It reads the register, computes the result and flags, then writes back and pulses done.
module xbit_r_exec #(
  parameter int RD_LATENCY = 1
) (
  input  logic       CLK,
  input  logic       notRESET,
  input  logic       start,
  input  logic [7:0] opcode,
  input  logic [6:0] reg_sel,
  input  logic [7:0] flags_in,
  input  logic [7:0] rf_rdata,
  output logic       rf_rd_en,
  output logic [6:0] rf_rd_sel,
  output logic       rf_wr_en,
  output logic [6:0] rf_wr_sel,
  output logic [7:0] rf_wdata,
  output logic [7:0] flags_out,
  output logic       flags_we,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {IDLE, READ, WAIT, EXEC, WRITE, FAIL} state_t;

  state_t     state_reg, state_next;
  logic [7:0] op_reg;
  logic [6:0] sel_reg;
  logic [7:0] result_reg, flags_reg;

  logic [6:0] dec_sel;
  logic       sel_onehot, illegal;
  logic [7:0] calc_result, calc_flags, bit_mask;
  logic       calc_carry;
  logic [2:0] bit_idx;

  // Register code to one-hot strobe; code 110 is (HL), which this block does not serve.
  always_comb begin
    dec_sel = 7'h00;
    case (opcode[2:0])
      3'b000:  dec_sel = 7'h01;
      3'b001:  dec_sel = 7'h02;
      3'b010:  dec_sel = 7'h04;
      3'b011:  dec_sel = 7'h08;
      3'b100:  dec_sel = 7'h10;
      3'b101:  dec_sel = 7'h20;
      3'b111:  dec_sel = 7'h40;
      default: dec_sel = 7'h00;
    endcase
  end

  assign sel_onehot = (reg_sel != 7'h00) && ((reg_sel & (reg_sel - 7'd1)) == 7'h00);
  assign illegal    = !sel_onehot || (opcode[2:0] == 3'b110) || (dec_sel != reg_sel);

  assign bit_idx  = op_reg[5:3];
  assign bit_mask = 8'h01 << bit_idx;

  always_comb begin
    calc_result = rf_rdata;
    calc_carry  = 1'b0;
    calc_flags  = flags_in;
    case (op_reg[7:6])
      2'b00: begin
        case (op_reg[5:3])
          3'd0: begin calc_result = {rf_rdata[6:0], rf_rdata[7]};  calc_carry = rf_rdata[7]; end
          3'd1: begin calc_result = {rf_rdata[0], rf_rdata[7:1]};  calc_carry = rf_rdata[0]; end
          3'd2: begin calc_result = {rf_rdata[6:0], flags_in[0]};  calc_carry = rf_rdata[7]; end
          3'd3: begin calc_result = {flags_in[0], rf_rdata[7:1]};  calc_carry = rf_rdata[0]; end
          3'd4: begin calc_result = {rf_rdata[6:0], 1'b0};         calc_carry = rf_rdata[7]; end
          3'd5: begin calc_result = {rf_rdata[7], rf_rdata[7:1]};  calc_carry = rf_rdata[0]; end
          3'd6: begin calc_result = {rf_rdata[6:0], 1'b1};         calc_carry = rf_rdata[7]; end
          default: begin calc_result = {1'b0, rf_rdata[7:1]};      calc_carry = rf_rdata[0]; end
        endcase
        calc_flags = {calc_result[7], (calc_result == 8'h00), calc_result[5], 1'b0,
                      calc_result[3], ~^calc_result, 1'b0, calc_carry};
      end
      2'b01: begin
        calc_flags = {(bit_idx == 3'd7) & rf_rdata[bit_idx], ~rf_rdata[bit_idx], rf_rdata[5], 1'b1,
                      rf_rdata[3], ~rf_rdata[bit_idx], 1'b0, flags_in[0]};
      end
      2'b10:   calc_result = rf_rdata & ~bit_mask;
      default: calc_result = rf_rdata | bit_mask;
    endcase
  end

  always_ff @(posedge CLK or negedge notRESET) begin
    if (!notRESET) begin
      state_reg  <= IDLE;
      op_reg     <= 8'h00;
      sel_reg    <= 7'h00;
      result_reg <= 8'h00;
      flags_reg  <= 8'h00;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && start) begin
        op_reg  <= opcode;
        sel_reg <= reg_sel;
      end
      if (state_reg == EXEC) begin
        result_reg <= calc_result;
        flags_reg  <= calc_flags;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = illegal ? FAIL : READ;
      READ:    state_next = (RD_LATENCY == 2) ? WAIT : EXEC;
      WAIT:    state_next = EXEC;
      EXEC:    state_next = WRITE;
      WRITE:   state_next = IDLE;
      FAIL:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign rf_rd_en  = (state_reg == READ);
  assign rf_rd_sel = sel_reg;
  assign rf_wr_sel = sel_reg;
  assign rf_wr_en  = (state_reg == WRITE) && (op_reg[7:6] != 2'b01);
  assign flags_we  = (state_reg == WRITE) && !op_reg[7];
  assign rf_wdata  = (state_reg == WRITE) ? result_reg : 8'h00;
  assign flags_out = (state_reg == WRITE) ? flags_reg : 8'h00;
  assign busy      = (state_reg != IDLE);
  assign done      = (state_reg == WRITE) || (state_reg == FAIL);
  assign err       = (state_reg == FAIL);

endmodule

// File: tb/tb_xbit_r_exec.sv
// Directed bench for xbit_r_exec: vector table for the datapath plus hand-built
// sequences for illegal requests, start-while-busy and mid-operation reset.
module tb_xbit_r_exec;

  logic       CLK = 1'b0;
  logic       notRESET;
  logic       start;
  logic [7:0] opcode;
  logic [6:0] reg_sel;
  logic [7:0] flags_in;
  logic [7:0] rf_rdata;
  logic       rf_rd_en;
  logic [6:0] rf_rd_sel;
  logic       rf_wr_en;
  logic [6:0] rf_wr_sel;
  logic [7:0] rf_wdata;
  logic [7:0] flags_out;
  logic       flags_we;
  logic       busy;
  logic       done;
  logic       err;

  int checks = 0;
  int failures = 0;

  xbit_r_exec #(.RD_LATENCY(1)) dut (
    .CLK(CLK), .notRESET(notRESET), .start(start), .opcode(opcode), .reg_sel(reg_sel),
    .flags_in(flags_in), .rf_rdata(rf_rdata), .rf_rd_en(rf_rd_en), .rf_rd_sel(rf_rd_sel),
    .rf_wr_en(rf_wr_en), .rf_wr_sel(rf_wr_sel), .rf_wdata(rf_wdata), .flags_out(flags_out),
    .flags_we(flags_we), .busy(busy), .done(done), .err(err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] op;
    logic [6:0] sel;
    logic [7:0] d;
    logic [7:0] fin;
    logic [7:0] wd;
    logic [7:0] fl;
    logic       wr;
    logic       fwe;
  } vec_t;

  vec_t vecs[12];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_op(input int idx, input vec_t v);
    string t;
    t = $sformatf("v%0d", idx);
    opcode = v.op; reg_sel = v.sel; rf_rdata = v.d; flags_in = v.fin;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({t, "_rd_en"}, {7'd0, rf_rd_en}, 8'd1);
    chk({t, "_rd_sel"}, {1'b0, rf_rd_sel}, {1'b0, v.sel});
    chk({t, "_done_read"}, {7'd0, done}, 8'd0);
    tick();
    chk({t, "_done_exec"}, {7'd0, done}, 8'd0);
    tick();
    chk({t, "_done"}, {7'd0, done}, 8'd1);
    chk({t, "_err"}, {7'd0, err}, 8'd0);
    chk({t, "_wr_en"}, {7'd0, rf_wr_en}, {7'd0, v.wr});
    chk({t, "_flags_we"}, {7'd0, flags_we}, {7'd0, v.fwe});
    if (v.wr) begin
      chk({t, "_wdata"}, rf_wdata, v.wd);
      chk({t, "_wr_sel"}, {1'b0, rf_wr_sel}, {1'b0, v.sel});
    end
    if (v.fwe) chk({t, "_flags_out"}, flags_out, v.fl);
    $display("op=%h sel=%h d=%h fin=%h -> wdata=%h flags=%h wr=%b fwe=%b",
             v.op, v.sel, v.d, v.fin, rf_wdata, flags_out, rf_wr_en, flags_we);
    tick();
    chk({t, "_busy_after"}, {7'd0, busy}, 8'd0);
    chk({t, "_done_after"}, {7'd0, done}, 8'd0);
  endtask

  task automatic run_illegal(input string t, input logic [7:0] op, input logic [6:0] sel);
    opcode = op; reg_sel = sel; rf_rdata = 8'hFF; flags_in = 8'h00;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({t, "_done"}, {7'd0, done}, 8'd1);
    chk({t, "_err"}, {7'd0, err}, 8'd1);
    chk({t, "_strobes"}, {5'd0, rf_rd_en, rf_wr_en, flags_we}, 8'd0);
    $display("illegal op=%h sel=%h -> done=%b err=%b", op, sel, done, err);
    tick();
    chk({t, "_idle"}, {6'd0, busy, done}, 8'd0);
  endtask

  initial begin
    int dcount;
    vecs[0]  = '{8'h00, 7'h01, 8'h85, 8'h00, 8'h0B, 8'h09, 1'b1, 1'b1}; // RLC B
    vecs[1]  = '{8'h3F, 7'h40, 8'h01, 8'h00, 8'h00, 8'h45, 1'b1, 1'b1}; // SRL A
    vecs[2]  = '{8'h7C, 7'h10, 8'h80, 8'h01, 8'h00, 8'h91, 1'b0, 1'b1}; // BIT 7,H
    vecs[3]  = '{8'hDB, 7'h08, 8'h00, 8'h00, 8'h08, 8'h00, 1'b1, 1'b0}; // SET 3,E
    vecs[4]  = '{8'h9B, 7'h08, 8'h08, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0}; // RES 3,E
    vecs[5]  = '{8'h19, 7'h02, 8'h01, 8'h01, 8'h80, 8'h81, 1'b1, 1'b1}; // RR C
    vecs[6]  = '{8'h2A, 7'h04, 8'hA4, 8'h00, 8'hD2, 8'h84, 1'b1, 1'b1}; // SRA D
    vecs[7]  = '{8'h45, 7'h20, 8'h28, 8'h00, 8'h00, 8'h7C, 1'b0, 1'b1}; // BIT 0,L
    vecs[8]  = '{8'h17, 7'h40, 8'h80, 8'h00, 8'h00, 8'h45, 1'b1, 1'b1}; // RL A
    vecs[9]  = '{8'h30, 7'h01, 8'h10, 8'h00, 8'h21, 8'h24, 1'b1, 1'b1}; // SLL B
    vecs[10] = '{8'hBF, 7'h40, 8'hFF, 8'h00, 8'h7F, 8'h00, 1'b1, 1'b0}; // RES 7,A
    vecs[11] = '{8'h24, 7'h10, 8'h88, 8'h00, 8'h10, 8'h01, 1'b1, 1'b1}; // SLA H

    notRESET = 1'b0; start = 1'b0; opcode = 8'h00; reg_sel = 7'h00;
    flags_in = 8'h00; rf_rdata = 8'h00;
    tick(); tick();
    chk("reset_ctrl", {2'd0, busy, done, err, rf_rd_en, rf_wr_en, flags_we}, 8'd0);
    chk("reset_wdata", rf_wdata, 8'h00);
    chk("reset_flags", flags_out, 8'h00);
    chk("reset_sel", {1'b0, rf_rd_sel}, 8'h00);
    notRESET = 1'b1;
    tick();

    for (int i = 0; i < 12; i++) run_op(i, vecs[i]);

    run_illegal("ill_sel", 8'h00, 7'h03);
    run_illegal("ill_hl", 8'h06, 7'h01);
    run_illegal("ill_mis", 8'h00, 7'h02);
    run_illegal("ill_zero", 8'h07, 7'h00);

    // start pulsed again while READ is in progress must be dropped
    opcode = 8'h00; reg_sel = 7'h01; rf_rdata = 8'h85; flags_in = 8'h00;
    start = 1'b1;
    tick();
    dcount = 0;
    for (int c = 0; c < 8; c++) begin
      if (c == 1) start = 1'b0;
      if (done) dcount++;
      tick();
    end
    start = 1'b0;
    chk("busy_start_dones", 8'(dcount), 8'd1);
    $display("start during READ -> done pulses=%0d", dcount);
    chk("busy_start_idle", {7'd0, busy}, 8'd0);

    // reset during EXEC: outputs drop without waiting for a clock edge
    opcode = 8'hDB; reg_sel = 7'h08; rf_rdata = 8'h00;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("pre_reset_exec_busy", {7'd0, busy}, 8'd1);
    #2 notRESET = 1'b0;
    #1;
    chk("async_rst_ctrl", {2'd0, busy, done, err, rf_rd_en, rf_wr_en, flags_we}, 8'd0);
    chk("async_rst_data", rf_wdata | flags_out, 8'h00);
    dcount = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (done || rf_wr_en) dcount++;
    end
    chk("rst_no_write", 8'(dcount), 8'd0);
    $display("reset during EXEC -> busy=%b done=%b wr_en=%b", busy, done, rf_wr_en);
    notRESET = 1'b1;
    tick();
    run_op(99, vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
